// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the RISC-V control units: opcodes, datapath mux selects,
// ALU and immediate codes, the multi-cycle state enum and trap causes.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [2:0] IMM_I  = 3'b000;
   localparam logic [2:0] IMM_S  = 3'b001;
   localparam logic [2:0] IMM_B  = 3'b010;
   localparam logic [2:0] IMM_JR = 3'b011;
   localparam logic [2:0] IMM_J  = 3'b100;
   localparam logic [2:0] IMM_U  = 3'b101;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
      S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_PC, S_LUI, S_TRAP
   } state_t;

   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BR:   return IMM_B;
         OP_JALR: return IMM_JR;
         OP_JAL:  return IMM_J;
         OP_LUI:  return IMM_U;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath/memory signal bundle; master is the control unit side.
interface multicycle_control_unit_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       Zero;
   logic       Neg;
   logic       mem_ready;

   logic       PCWrite;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       AdrSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [2:0] ALUControl;
   logic [2:0] ImmSrc;
   logic       instr_done;
   logic       trap;
   logic [1:0] trap_cause;

   modport master (
      input  op, funct3, funct7, Zero, Neg, mem_ready,
      output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ALUControl, ImmSrc, instr_done, trap, trap_cause
   );

   modport slave (
      output op, funct3, funct7, Zero, Neg, mem_ready,
      input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ALUControl, ImmSrc, instr_done, trap, trap_cause
   );

endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU operation select and instruction legality check from op/funct3/funct7.
module alu_decoder
   import riscv_ctrl_pkg::*;
#(
   parameter int SUPPORT_SIGNED_BRANCH = 1
) (
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [2:0] alu_control_o,
   output logic       legal_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      legal_o       = 1'b0;
      case (op_i)
         OP_R: begin
            legal_o = 1'b1;
            case ({funct7_i, funct3_i})
               10'b0000000_000: alu_control_o = ALU_ADD;
               10'b0100000_000: alu_control_o = ALU_SUB;
               10'b0000000_111: alu_control_o = ALU_AND;
               10'b0000000_110: alu_control_o = ALU_OR;
               10'b0000000_010: alu_control_o = ALU_SLT;
               default:         legal_o = 1'b0;
            endcase
         end
         OP_I: begin
            legal_o = 1'b1;
            case (funct3_i)
               3'b000:  alu_control_o = ALU_ADD;
               3'b110:  alu_control_o = ALU_OR;
               3'b010:  alu_control_o = ALU_SLT;
               default: legal_o = 1'b0;
            endcase
         end
         OP_BR: begin
            alu_control_o = ALU_SUB;
            legal_o = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                      ((SUPPORT_SIGNED_BRANCH != 0) &&
                       ((funct3_i == 3'b100) || (funct3_i == 3'b101)));
         end
         OP_JALR:                      legal_o = (funct3_i == 3'b000);
         OP_LW, OP_SW, OP_JAL, OP_LUI: legal_o = 1'b1;
         default:                      legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style multi-cycle RV32I control FSM with memory-stall timeout and sticky trap.
// Strobes decode from the registered state; only branch PCWrite and FETCH/MEM_WRITE use live inputs.
module multicycle_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int SUPPORT_SIGNED_BRANCH = 1,
   parameter int WAIT_LIMIT            = 15
) (
   input logic                        clk,
   input logic                        rst,
   multicycle_control_unit_if.master  bus
);

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       trap_q, trap_d;
   logic [1:0] cause_q, cause_d;
   logic [2:0] dec_alu;
   logic       dec_legal;
   logic       stall_state;
   logic       taken;
   logic [7:0] wait_inc;

   alu_decoder #(.SUPPORT_SIGNED_BRANCH(SUPPORT_SIGNED_BRANCH)) u_alu_dec (
      .op_i          (bus.op),
      .funct3_i      (bus.funct3),
      .funct7_i      (bus.funct7),
      .alu_control_o (dec_alu),
      .legal_o       (dec_legal)
   );

   assign stall_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
   assign wait_inc    = wait_q + 8'd1;

   always_comb begin
      case (bus.funct3)
         3'b000:  taken = bus.Zero;
         3'b001:  taken = ~bus.Zero;
         3'b100:  taken = bus.Neg;
         3'b101:  taken = ~bus.Neg;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      trap_d  = trap_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEM_ADR;
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR_ADR;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_TRAP;
            endcase
            if (!dec_legal || state_d == S_TRAP) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_MEM_ADR:   state_d = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
         S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_PC: state_d = S_ALU_WB;
         S_JALR_ADR:  state_d = S_JALR_PC;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_FETCH;
      endcase
      // A completing access always wins over the stall limit.
      if (stall_state && !bus.mem_ready) begin
         if (wait_inc == WAIT_LIM) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_TIMEOUT;
         end else begin
            wait_d = wait_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         trap_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      bus.PCWrite    = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ALUSrcA    = SRCA_PC;
      bus.ALUSrcB    = SRCB_RS2;
      bus.ResultSrc  = RES_ALUOUT;
      bus.ALUControl = ALU_ADD;
      bus.ImmSrc     = IMM_I;
      bus.instr_done = 1'b0;
      bus.trap       = 1'b0;
      bus.trap_cause = CAUSE_NONE;
      if (!rst) begin
         bus.trap       = trap_q;
         bus.trap_cause = cause_q;
         case (state_q)
            S_FETCH: begin
               bus.ALUSrcB   = SRCB_FOUR;
               bus.ResultSrc = RES_ALURES;
               bus.IRWrite   = bus.mem_ready;
               bus.PCWrite   = bus.mem_ready;
            end
            S_DECODE: begin
               bus.ALUSrcA = SRCA_OLDPC;
               bus.ALUSrcB = SRCB_IMM;
               bus.ImmSrc  = imm_src_of(bus.op);
            end
            S_MEM_ADR, S_JALR_ADR: begin
               bus.ALUSrcA = SRCA_RS1;
               bus.ALUSrcB = SRCB_IMM;
               bus.ImmSrc  = imm_src_of(bus.op);
            end
            S_MEM_READ: bus.AdrSrc = 1'b1;
            S_MEM_WB: begin
               bus.ResultSrc  = RES_DATA;
               bus.RegWrite   = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
               bus.AdrSrc     = 1'b1;
               bus.MemWrite   = 1'b1;
               bus.instr_done = bus.mem_ready;
            end
            S_EXEC_R: begin
               bus.ALUSrcA    = SRCA_RS1;
               bus.ALUControl = dec_alu;
            end
            S_EXEC_I: begin
               bus.ALUSrcA    = SRCA_RS1;
               bus.ALUSrcB    = SRCB_IMM;
               bus.ALUControl = dec_alu;
               bus.ImmSrc     = imm_src_of(bus.op);
            end
            S_ALU_WB: begin
               bus.RegWrite   = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
               bus.ALUSrcA    = SRCA_RS1;
               bus.ALUControl = ALU_SUB;
               bus.PCWrite    = taken;
               bus.instr_done = 1'b1;
            end
            S_JAL, S_JALR_PC: begin
               bus.ALUSrcA = SRCA_OLDPC;
               bus.ALUSrcB = SRCB_FOUR;
               bus.PCWrite = 1'b1;
            end
            S_LUI: begin
               bus.ResultSrc  = RES_IMM;
               bus.ImmSrc     = IMM_U;
               bus.RegWrite   = 1'b1;
               bus.instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multi-cycle control unit (signed branches disabled, WAIT_LIMIT 15).
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       pcw, irw, memw, regw, adr;
      logic [1:0] srca, srcb, res;
      logic [2:0] aluc, imm;
      logic       done, trap;
      logic [1:0] cause;
   } outs_t;

   localparam outs_t Z      = '0;
   localparam outs_t F_RDY  = '{pcw:1'b1, irw:1'b1, srcb:2'b10, res:2'b10, default:'0};
   localparam outs_t F_STL  = '{srcb:2'b10, res:2'b10, default:'0};
   localparam outs_t AWB    = '{regw:1'b1, done:1'b1, default:'0};
   localparam outs_t DEC_I  = '{srca:2'b01, srcb:2'b01, imm:3'b000, default:'0};

   logic  clk = 1'b0;
   logic  rst;
   int    n_checks = 0;
   int    n_fail   = 0;
   outs_t obs;

   always #5 clk = ~clk;

   multicycle_control_unit_if bus();

   multicycle_control_unit #(.SUPPORT_SIGNED_BRANCH(0), .WAIT_LIMIT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic outs_t sample();
      return {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.AdrSrc,
              bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.ImmSrc,
              bus.instr_done, bus.trap, bus.trap_cause};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
      bus.op = o;
      bus.funct3 = f3;
      bus.funct7 = f7;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      set_instr(7'b0110011, 3'b000, 7'b0);
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      next_cycle();
      @(negedge clk);
      obs = sample();
      n_checks++;
      if (obs !== Z) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, Z); end
      next_cycle();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      obs = sample();
      n_checks++;
      if (obs !== F_STL) begin n_fail++; $display("FAIL reset_fetch: got %h want %h", obs, F_STL); end
      next_cycle();
   endtask

   task automatic test_add();
      outs_t e [4];
      e = '{F_RDY, DEC_I, '{srca:2'b10, default:'0}, AWB};
      set_instr(7'b0110011, 3'b000, 7'b0);
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         obs = sample();
         n_checks++;
         if (obs !== e[i]) begin n_fail++; $display("FAIL add c%0d: got %h want %h", i + 1, obs, e[i]); end
         next_cycle();
      end
   endtask

   task automatic test_alu_variants();
      logic [6:0] ops [4];
      logic [2:0] f3s [4];
      logic [6:0] f7s [4];
      outs_t      ex  [4];
      outs_t      e;
      ops = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
      f3s = '{3'b000, 3'b010, 3'b111, 3'b110};
      f7s = '{7'b0100000, 7'b0, 7'b0, 7'b0};
      ex  = '{'{srca:2'b10, aluc:3'b001, default:'0}, '{srca:2'b10, aluc:3'b100, default:'0},
              '{srca:2'b10, aluc:3'b010, default:'0},
              '{srca:2'b10, srcb:2'b01, aluc:3'b011, default:'0}};
      bus.mem_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         set_instr(ops[v], f3s[v], f7s[v]);
         for (int i = 0; i < 4; i++) begin
            e = (i == 0) ? F_RDY : (i == 1) ? DEC_I : (i == 2) ? ex[v] : AWB;
            @(negedge clk);
            obs = sample();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL alu_v%0d c%0d: got %h want %h", v, i + 1, obs, e); end
            next_cycle();
         end
      end
   endtask

   task automatic test_lw_stall();
      outs_t e [8];
      logic  rdy [8];
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      e = '{F_RDY, DEC_I, '{srca:2'b10, srcb:2'b01, default:'0},
            '{adr:1'b1, default:'0}, '{adr:1'b1, default:'0}, '{adr:1'b1, default:'0},
            '{adr:1'b1, default:'0}, '{res:2'b01, regw:1'b1, done:1'b1, default:'0}};
      set_instr(7'b0000011, 3'b010, 7'b0);
      for (int i = 0; i < 8; i++) begin
         bus.mem_ready = rdy[i];
         @(negedge clk);
         obs = sample();
         n_checks++;
         if (obs !== e[i]) begin n_fail++; $display("FAIL lw c%0d: got %h want %h", i + 1, obs, e[i]); end
         next_cycle();
      end
   endtask

   task automatic test_sw_and_reset_mid_write();
      outs_t e   [7];
      logic  rdy [7];
      logic  rs  [7];
      for (int pass = 0; pass < 2; pass++) begin
         rdy = '{1'b1, 1'b1, 1'b1, 1'b0, (pass == 0), 1'b0, 1'b0};
         rs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
         e = '{F_RDY, '{srca:2'b01, srcb:2'b01, imm:3'b001, default:'0},
               '{srca:2'b10, srcb:2'b01, imm:3'b001, default:'0},
               '{memw:1'b1, adr:1'b1, default:'0},
               '{memw:1'b1, adr:1'b1, done:(pass == 0), default:'0}, Z, F_STL};
         set_instr(7'b0100011, 3'b010, 7'b0);
         for (int i = 0; i < ((pass == 0) ? 5 : 7); i++) begin
            rst = rs[i];
            bus.mem_ready = rdy[i];
            @(negedge clk);
            obs = sample();
            n_checks++;
            if (obs !== e[i]) begin n_fail++; $display("FAIL sw_p%0d c%0d: got %h want %h", pass, i + 1, obs, e[i]); end
            next_cycle();
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_branch();
      outs_t e;
      bus.mem_ready = 1'b1;
      bus.Zero = 1'b1;
      bus.Neg = 1'b0;
      for (int b = 0; b < 2; b++) begin
         set_instr(7'b1100011, (b == 0) ? 3'b000 : 3'b001, 7'b0);
         for (int i = 0; i < 3; i++) begin
            e = (i == 0) ? F_RDY : (i == 1) ? '{srca:2'b01, srcb:2'b01, imm:3'b010, default:'0}
                : '{pcw:(b == 0), srca:2'b10, aluc:3'b001, done:1'b1, default:'0};
            @(negedge clk);
            obs = sample();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL branch_b%0d c%0d: got %h want %h", b, i + 1, obs, e); end
            if (i == 2 && b == 1) begin
               bus.Zero = 1'b0;
               #1;
               n_checks++;
               if (bus.PCWrite !== 1'b1) begin n_fail++; $display("FAIL bne_flag_flip: got %b want 1", bus.PCWrite); end
               bus.Zero = 1'b1;
            end
            next_cycle();
         end
      end
   endtask

   task automatic test_jumps_lui();
      outs_t e [3][5];
      int    len [3];
      logic [6:0] ops [3];
      ops = '{7'b1101111, 7'b1100111, 7'b0110111};
      len = '{4, 5, 3};
      e[0] = '{F_RDY, '{srca:2'b01, srcb:2'b01, imm:3'b100, default:'0},
               '{pcw:1'b1, srca:2'b01, srcb:2'b10, default:'0}, AWB, Z};
      e[1] = '{F_RDY, '{srca:2'b01, srcb:2'b01, imm:3'b011, default:'0},
               '{srca:2'b10, srcb:2'b01, imm:3'b011, default:'0},
               '{pcw:1'b1, srca:2'b01, srcb:2'b10, default:'0}, AWB};
      e[2] = '{F_RDY, '{srca:2'b01, srcb:2'b01, imm:3'b101, default:'0},
               '{regw:1'b1, res:2'b11, imm:3'b101, done:1'b1, default:'0}, Z, Z};
      bus.mem_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         set_instr(ops[t], 3'b000, 7'b0);
         for (int i = 0; i < len[t]; i++) begin
            @(negedge clk);
            obs = sample();
            n_checks++;
            if (obs !== e[t][i]) begin n_fail++; $display("FAIL jump_t%0d c%0d: got %h want %h", t, i + 1, obs, e[t][i]); end
            next_cycle();
         end
      end
   endtask

   task automatic test_illegal();
      outs_t e [6];
      logic [6:0] ops [3];
      logic [2:0] f3s [3];
      ops = '{7'b1100011, 7'b0110011, 7'b1111111};
      f3s = '{3'b100, 3'b001, 3'b000};
      for (int t = 0; t < 3; t++) begin
         e = '{F_RDY, '{srca:2'b01, srcb:2'b01, imm:((t == 0) ? 3'b010 : 3'b000), default:'0},
               '{trap:1'b1, cause:2'b01, default:'0}, '{trap:1'b1, cause:2'b01, default:'0}, Z, F_STL};
         set_instr(ops[t], f3s[t], 7'b0);
         bus.Zero = 1'b1;
         for (int i = 0; i < 6; i++) begin
            rst = (i == 4);
            bus.mem_ready = (i < 4);
            @(negedge clk);
            obs = sample();
            n_checks++;
            if (obs !== e[i]) begin n_fail++; $display("FAIL illegal_t%0d c%0d: got %h want %h", t, i + 1, obs, e[i]); end
            next_cycle();
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_timeout();
      outs_t e;
      set_instr(7'b0110011, 3'b000, 7'b0);
      do_reset();
      for (int i = 0; i < 17; i++) begin
         bus.mem_ready = (i == 16);
         e = (i < 15) ? F_STL : '{trap:1'b1, cause:2'b10, default:'0};
         @(negedge clk);
         obs = sample();
         n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL timeout c%0d: got %h want %h", i + 1, obs, e); end
         next_cycle();
      end
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.mem_ready = (i == 14);
         e = (i < 14) ? F_STL : (i == 14) ? F_RDY : DEC_I;
         @(negedge clk);
         obs = sample();
         n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL limit_edge c%0d: got %h want %h", i + 1, obs, e); end
         next_cycle();
      end
      do_reset();
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      bus.Zero = 1'b0;
      bus.Neg = 1'b0;
      set_instr(7'b0, 3'b0, 7'b0);
      test_reset();
      test_add();
      test_alu_variants();
      test_lw_stall();
      test_sw_and_reset_mid_write();
      test_branch();
      test_jumps_lui();
      test_illegal();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
